// File: rtl/debug_pkg.sv
// Shared command codes, reply bytes, FSM encoding and dump layout for debug_unit.
// The dump layout grows by one item (the cycle counter) when DEBUG_UNIT_CYCLE_CNT_EN is defined.
package debug_pkg;

  localparam int NB_BYTE = 8;

  localparam logic [7:0] CMD_RUN  = 8'h01;
  localparam logic [7:0] CMD_STEP = 8'h02;
  localparam logic [7:0] CMD_DUMP = 8'h03;
  localparam logic [7:0] CMD_HALT = 8'h04;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  // Items ahead of the register file: PC, plus the cycle counter when enabled.
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
  localparam int PRE_ITEMS = 2;
`else
  localparam int PRE_ITEMS = 1;
`endif
  localparam int RF_ITEMS  = 32;
  localparam int IDX_W     = 7;

  typedef enum logic [3:0] {
    IDLE, RUN, STEP, LOAD_WAIT, LOAD, SEND, TX_WAIT, NEXT, ACK
  } state_t;

endpackage

// File: rtl/dbg_word_tx.sv
// Serialises one word to the UART transmitter, MSB byte first, one tx_start per byte.
// Latency: first tx_start the cycle after i_load when the transmitter is idle; o_done pulses after the last byte drains.
// Backpressure: each byte waits for i_tx_busy=0; the cycle right after a start is skipped because busy rises one cycle late.
module dbg_word_tx #(
  parameter int NB_BITS = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [NB_BITS-1:0] i_word,
  input  logic               i_tx_busy,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_done
);
  import debug_pkg::*;

  localparam int N_BYTES = NB_BITS / NB_BYTE;
  localparam int CNT_W   = $clog2(N_BYTES);

  state_t             state, state_nxt;
  logic [NB_BITS-1:0] shift;
  logic [CNT_W-1:0]   byte_cnt;
  logic               first;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      shift    <= '0;
      byte_cnt <= '0;
      first    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (i_load) begin
          shift    <= i_word;
          byte_cnt <= CNT_W'(N_BYTES - 1);
        end
        SEND: if (!i_tx_busy) first <= 1'b1;
        TX_WAIT: begin
          if (first) begin
            first <= 1'b0;
          end else if (!i_tx_busy) begin
            shift <= shift << NB_BYTE;
            if (byte_cnt != '0) byte_cnt <= byte_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    o_tx_start = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: if (i_load) state_nxt = SEND;
      SEND: if (!i_tx_busy) begin
        o_tx_start = 1'b1;
        state_nxt  = TX_WAIT;
      end
      TX_WAIT: if (!first && !i_tx_busy) begin
        if (byte_cnt != '0) begin
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
          o_done    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_tx_data = shift[NB_BITS-1 -: NB_BYTE];

endmodule

// File: rtl/debug_unit.sv
// UART-driven debug controller: run/halt/single-step the pipeline and dump PC, RF and a data-memory window.
// Latency: two settle cycles per dump item before its first byte; optional cycle counter under DEBUG_UNIT_CYCLE_CNT_EN.
// Backpressure: tx paced by i_tx_busy; rx bytes outside IDLE/RUN are dropped, never queued.
module debug_unit #(
  parameter int NB_BITS   = 32,
  parameter int NB_REG    = 5,
  parameter int NB_BYTE   = 8,
  parameter int MEM_WORDS = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_busy,
  output logic               o_debug_enb,
  output logic               o_step,
  output logic [NB_REG-1:0]  o_rf_addr,
  output logic [NB_BITS-1:0] o_mem_addr,
  input  logic [NB_BITS-1:0] i_pc_debug,
  input  logic [NB_BITS-1:0] i_rf_data,
  input  logic [NB_BITS-1:0] i_mem_data,
  input  logic               i_halt
);
  import debug_pkg::*;

  localparam logic [IDX_W-1:0] RF_BASE   = IDX_W'(PRE_ITEMS);
  localparam logic [IDX_W-1:0] MEM_BASE  = IDX_W'(PRE_ITEMS + RF_ITEMS);
  localparam logic [IDX_W-1:0] LAST_ITEM = IDX_W'(PRE_ITEMS + RF_ITEMS + MEM_WORDS - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt, mem_off;
  logic [NB_REG-1:0]  rf_off;
  logic [NB_BYTE-1:0] reply, reply_nxt, w_tx_data;
  logic [NB_BITS-1:0] word;
  logic               word_load, word_done, w_tx_start, ack_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      idx   <= '0;
      reply <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      reply <= reply_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    reply_nxt = reply;
    word_load = 1'b0;
    ack_start = 1'b0;
    case (state)
      IDLE: if (i_rx_valid) begin
        case (i_rx_data)
          CMD_RUN:  state_nxt = RUN;
          CMD_STEP: state_nxt = STEP;
          CMD_DUMP: begin state_nxt = LOAD_WAIT; idx_nxt = '0; end
          CMD_HALT: ;
          default:  begin state_nxt = ACK; reply_nxt = ERR_BYTE; end
        endcase
      end
      // The halt pin and an rx HALT on the same cycle produce a single acknowledge.
      RUN: if (i_halt || (i_rx_valid && i_rx_data == CMD_HALT)) begin
        state_nxt = ACK;
        reply_nxt = ACK_BYTE;
      end
      STEP:      begin state_nxt = LOAD_WAIT; idx_nxt = '0; end
      LOAD_WAIT: state_nxt = LOAD;
      LOAD:      begin word_load = 1'b1; state_nxt = SEND; end
      SEND:      if (word_done) state_nxt = NEXT;
      NEXT: if (idx == LAST_ITEM) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end else begin
        state_nxt = LOAD_WAIT;
        idx_nxt   = idx + IDX_W'(1);
      end
      ACK: if (!i_tx_busy) begin
        ack_start = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses follow the item index so they are stable for the whole LOAD_WAIT/LOAD pair.
  assign rf_off     = NB_REG'(idx - RF_BASE);
  assign mem_off    = idx - MEM_BASE;
  assign o_rf_addr  = (idx >= RF_BASE && idx < MEM_BASE) ? rf_off : '0;
  assign o_mem_addr = (idx >= MEM_BASE) ? {{(NB_BITS-IDX_W-2){1'b0}}, mem_off, 2'b00} : '0;

  assign o_debug_enb = (state != RUN);
  assign o_step      = (state == STEP);

`ifdef DEBUG_UNIT_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) cycle_cnt <= '0;
    else if ((!o_debug_enb || o_step) && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  always_comb begin
    word = i_pc_debug;
    if (idx >= MEM_BASE)     word = i_mem_data;
    else if (idx >= RF_BASE) word = i_rf_data;
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
    else if (idx == IDX_W'(1)) word = NB_BITS'(cycle_cnt);
`endif
  end

  dbg_word_tx #(.NB_BITS(NB_BITS), .NB_BYTE(NB_BYTE)) u_word_tx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (word_load),
    .i_word     (word),
    .i_tx_busy  (i_tx_busy),
    .o_tx_data  (w_tx_data),
    .o_tx_start (w_tx_start),
    .o_done     (word_done)
  );

  assign o_tx_start = w_tx_start | ack_start;
  assign o_tx_data  = (state == ACK) ? reply : w_tx_data;

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Debug controller that sits directly upstream of the Mips top and drives its debug hooks: pipeline enable, single-step, and register-file/data-memory debug addresses.
- Consumes the pipeline's debug read-back data.
- Takes command bytes from a UART receiver, halts, runs or single-steps the pipeline, and streams pipeline state (PC, register file, data-memory window) back to a UART transmitter.
- The counterpart the pipeline's debug/step inputs are currently tied off waiting for.

Parameters:
- NB_BITS, 32, datapath word width.
- NB_REG, 5, register-file address width.
- NB_BYTE, 8, UART byte width.
- MEM_WORDS, 16, number of data-memory words dumped, starting at word address 0.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  one-cycle pulse; i_rx_data valid.
- o_tx_data  out  NB_BYTE  byte to transmit.
- o_tx_start  out  1  one-cycle pulse requesting transmission.
- i_tx_busy  in  1  transmitter busy; rises the cycle after o_tx_start.
- o_debug_enb  out  1  1 = pipeline frozen under debug control.
- o_step  out  1  one-cycle pulse advancing the frozen pipeline one clock.
- o_rf_addr  out  NB_REG  register-file debug read address.
- o_mem_addr  out  NB_BITS  data-memory debug byte address (word index × 4).
- i_pc_debug  in  NB_BITS  current PC.
- i_rf_data  in  NB_BITS  register-file data; combinational from o_rf_addr.
- i_mem_data  in  NB_BITS  data-memory data; valid one cycle after o_mem_addr.
- i_halt  in  1  HALT instruction has reached write-back.

Behaviour:
- Reset values: o_debug_enb=1, o_step=0, o_tx_start=0, o_tx_data=0, o_rf_addr=0, o_mem_addr=0; FSM in IDLE.
- Reset mid-dump or mid-run aborts immediately; no further tx bytes are issued.
- Command bytes:
  - 0x01 RUN
  - 0x02 STEP
  - 0x03 DUMP
  - 0x04 HALT (honoured only in RUN)
  - any other byte in IDLE → reply 0xEE, return to IDLE.
- FSM states: IDLE, RUN, STEP, LOAD_WAIT, LOAD, SEND, TX_WAIT, NEXT, ACK.
- IDLE: waits for i_rx_valid.
  - RUN → o_debug_enb=0, enter RUN.
  - STEP → o_step=1 for exactly one cycle, enter STEP.
  - DUMP → enter LOAD_WAIT with item index 0.
- RUN: o_debug_enb=0 until i_halt or an rx HALT command (HALT wins on the same cycle), then o_debug_enb=1 on the next edge and go to ACK. Other rx bytes are dropped.
- ACK: sends 0xA5, then returns to IDLE.
- STEP: one cycle after the o_step pulse, falls into the dump sequence (auto-dump).
- Dump order:
  - PC
  - R0..R31
  - mem words 0..MEM_WORDS-1
  - each word sent MSB byte first.
- Dump length: 4·(33+MEM_WORDS) bytes (196 at default).
- LOAD_WAIT: drives the address for the current item and holds it one cycle. Both sources are treated uniformly with a one-cycle settle.
- LOAD: latches the source into a 32-bit shift register; byte counter = 3.
- SEND: when i_tx_busy=0, o_tx_data = shift[31:24] and o_tx_start=1 for one cycle → TX_WAIT.
- TX_WAIT: skips the first cycle, then waits for i_tx_busy=0. Shifts left 8 bits. If the byte counter ≠ 0, decrement it and go to SEND; otherwise go to NEXT.
- NEXT: increments the item index. At the last item, go to IDLE; otherwise go to LOAD_WAIT.
- The index is a 7-bit counter; no wrap within a dump.
- o_debug_enb stays 1 throughout STEP and dump.
- rx bytes arriving outside IDLE/RUN are dropped silently (no queueing).
- Simultaneous i_rx_valid and end of dump: the byte is dropped (FSM is in NEXT, not IDLE).

Optional Feature:
- Macro: DEBUG_UNIT_CYCLE_CNT_EN.
- When defined:
  - A 32-bit counter increments every clock with o_debug_enb=0 or o_step=1.
  - The counter clears on reset only and saturates at 0xFFFFFFFF.
  - It is inserted in the dump after PC; dump length becomes 4·(34+MEM_WORDS).
- When undefined: no counter logic; dump as above.

Decomposition:
- Shared package debug_pkg holds:
  - command codes CMD_RUN/CMD_STEP/CMD_DUMP/CMD_HALT
  - reply bytes ACK_BYTE=0xA5, ERR_BYTE=0xEE
  - FSM state encoding
  - NB_BYTE
  - dump item-count constants.
- One natural sub-module: dbg_word_tx. It takes a 32-bit word plus a load strobe, performs the 4-byte MSB-first tx handshake, and returns done. The top FSM then only sequences items.

Test Plan:
- Reset, then DUMP with PC=0x00000010, Rk=k, mem[w]=0x1000+w → 196 bytes; first four bytes are 00 00 00 10; R5 bytes are 00 00 00 05; last word is 00 00 10 0F; o_debug_enb stays 1.
- STEP → exactly one o_step pulse of width 1; pipeline PC advances by 4; auto-dump begins with the new PC.
- RUN, then i_halt asserted after 50 cycles → o_debug_enb=0 for those cycles, returns to 1; a single 0xA5 byte is sent.
- RUN, then HALT byte and i_halt on the same cycle → exactly one 0xA5 sent; FSM returns to IDLE.
- Byte 0x7F in IDLE → 0xEE sent. A byte sent mid-dump → ignored; dump byte count unchanged.
- i_rst asserted during byte 100 of a dump → outputs at reset values next cycle; no further o_tx_start. With DEBUG_UNIT_CYCLE_CNT_EN, RUN for 50 cycles then DUMP → counter word reads 0x00000032 and dump is 200 bytes.
